alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle controller that owns a small register file and sequences the shared `mod_alu` datapath. It accepts one command at a time: ALU op code, two source registers and one destination register. It drives registered operands and the op select to the ALU, captures the ALU result and flags, then writes them back. It sits between the control unit's command source and the ALU, and is the only driver of the ALU inputs.

## Interface
Parameters:
- `width`, 4, data width of the register file and ALU operands; must match the connected `mod_alu`
- `regs`, 4, number of registers; fixed at 4 (2-bit indices)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  command valid; sampled only in IDLE
- `op`  in  4  ALU select code, forwarded unchanged to `alu_sel`
- `rs1`, `rs2`, `rd`  in  2 each  source A, source B and destination register indices
- `wr_en`  in  1  external register load strobe
- `wr_addr`  in  2  external load index
- `wr_data`  in  width  external load data
- `rd_addr`  in  2  debug read index
- `rd_data`  out  width  combinational read of `rf[rd_addr]`
- `alu_a`, `alu_b`  out  width  registered ALU operands
- `alu_sel`  out  4  registered ALU op select
- `alu_result`  in  width  ALU result
- `alu_cout`, `alu_negative`, `alu_zero`  in  1 each  ALU flags
- `busy`  out  1  high while a command is in flight
- `done`  out  1  one-cycle pulse when writeback completes
- `flags`  out  3  {C,N,Z} from the last completed command

## Operation
- FSM states and transitions:
  - IDLE → EXEC on `start`.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- Reset (asynchronous, any state):
  - state IDLE; all registers, including every `rf` entry, to 0.
  - `alu_a`, `alu_b` and `alu_sel` to 0.
  - `busy`, `done` and `flags` to 0.
- IDLE with `start`=1: latch `alu_a`←`rf[rs1]`, `alu_b`←`rf[rs2]`, `alu_sel`←`op`, and latch `rd` internally.
- EXEC: capture `alu_result` and the three flags into holding registers. `alu_*` outputs are held stable.
- WB:
  - `rf[rd_latched]`←held result.
  - `flags`←{held C, held N, held Z}.
  - `done`=1 for the following cycle.
- External load: `wr_en` in IDLE writes `rf[wr_addr]`←`wr_data`.
  - `wr_en` is ignored while busy.
  - If `start` and `wr_en` are both high in IDLE, `start` wins and the load is dropped.
- `start` in EXEC or WB is ignored; it is not queued.
- `rs1`, `rs2` or `rd` may alias each other. The operands read are the pre-writeback values of the same command. No hazard exists across commands because writeback completes before IDLE.
- `alu_a`, `alu_b` and `alu_sel` hold their last values in IDLE. They are not cleared after a command.
- The block performs no arithmetic. Width and flag semantics are entirely the ALU's.

## Timing
- Start sampled at edge N:
  - after N: EXEC, `busy`=1.
  - after N+1: WB.
  - after N+2: IDLE, `busy`=0, `done`=1, `rf` and `flags` updated.
- Latency from `start` sample to `done` high is 3 edges. Throughput is one command per 3 cycles.
- A new `start` at edge N+3, while `done` is high, is accepted.
- `done` is cleared at edge N+3 regardless of `start`.
- `busy` is registered and equals (state≠IDLE). `rd_data` reflects a write on the cycle after the write edge.
- ALU combinational delay must fit within one cycle: `alu_*` registered at N, result captured at N+1.
- If `rst` is asserted mid-command, the command is abandoned immediately: no writeback, no `done` pulse, `busy` drops asynchronously.

## Test plan
Bench connects `mod_alu` with `width`=4.
- Reset, then probe `rd_data` for addr 0-3 → all 0. `busy`=`done`=0, `flags`=000, `alu_sel`=0000.
- Load r1=3, r2=5, then `start` op=0000 rs1=1 rs2=2 rd=3.
  - `busy` high for 2 cycles.
  - `done` pulse 3 edges after start.
  - r3=8, `flags`=000.
- Load r1=8, r2=8, then op=0000 rd=0 → r0=0, `flags`=101 (C=1, Z=1).
- r1=3, r2=5, op=0001 rd=3 → r3=2 (magnitude), `flags`=010 (N=1). Then op=0001 rs1=rs2=2 → result 0, `flags`=001.
- Busy and priority collisions:
  - Pulse `start` again during EXEC and WB → ignored; exactly one `done`.
  - `start` with `wr_en` in IDLE → command runs and the load is dropped.
  - `wr_en` while busy → `rf` unchanged.
- Assert `rst` during WB → `busy`=0 immediately, no `done`, all `rf` entries 0. A fresh command afterward completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: owns a 4-entry register file and drives a shared ALU through IDLE/EXEC/WB.
module alu_sequencer #(
  parameter int width = 4,
  parameter int regs = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [1:0]       rs1,
  input  logic [1:0]       rs2,
  input  logic [1:0]       rd,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [width-1:0] wr_data,
  input  logic [1:0]       rd_addr,
  output logic [width-1:0] rd_data,
  output logic [width-1:0] alu_a,
  output logic [width-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [width-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic             busy,
  output logic             done,
  output logic [2:0]       flags
);
  typedef enum logic [1:0] {idle, exec, wb} state_t;
  state_t state;
  logic [width-1:0] rf [regs];
  logic [width-1:0] hold_result;
  logic [2:0] hold_flags;
  logic [1:0] rd_q;
  assign rd_data = rf[rd_addr];
  // start outranks wr_en in idle; both are ignored once a command is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= idle;
      for (int i = 0; i < regs; i++) rf[i] <= '0;
      hold_result <= '0;
      hold_flags <= '0;
      rd_q <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      flags <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        idle: begin
          if (start) begin
            alu_a <= rf[rs1];
            alu_b <= rf[rs2];
            alu_sel <= op;
            rd_q <= rd;
            busy <= 1'b1;
            state <= exec;
          end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
          end
        end
        exec: begin
          hold_result <= alu_result;
          hold_flags <= {alu_cout, alu_negative, alu_zero};
          state <= wb;
        end
        default: begin
          rf[rd_q] <= hold_result;
          flags <= hold_flags;
          done <= 1'b1;
          busy <= 1'b0;
          state <= idle;
        end
      endcase
    end
  end
endmodule
